// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    BITS      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  localparam logic [3:0] LAST_BIT_IDX = 4'd9;
  localparam logic [3:0] PAR_BIT_IDX  = 4'd8;

  // Odd parity bit: makes the total number of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes raw PS2_CLK/PS2_DAT and flags synchronized clock falling edges.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clk_raw_i,
  input  logic dat_raw_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;

  // Shift chains reset to the idle (released, pulled-up) bus level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= SYNC_STAGES'({clk_sync_q, clk_raw_i});
      dat_sync_q <= SYNC_STAGES'({dat_sync_q, dat_raw_i});
      clk_prev_q <= clk_s_o;
    end
  end

  assign clk_s_o = clk_sync_q[SYNC_STAGES-1];
  assign dat_s_o = dat_sync_q[SYNC_STAGES-1];
  assign fall_o  = clk_prev_q & ~clk_s_o;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter; drives the open-drain lines via oe outputs only.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       ack_ok
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                      : INHIBIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             ack_q, ack_d;

  logic clk_oe_q, clk_oe_d;
  logic dat_oe_q, dat_oe_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic ack_ok_q, ack_ok_d;

  logic clk_s, dat_s, fall;
  logic watched_c, timeout_c, fin_ok_c, fin_err_c, cur_bit_c;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i     (CLOCK_50),
    .rst_ni    (resetn),
    .clk_raw_i (ps2_clk_in),
    .dat_raw_i (ps2_dat_in),
    .clk_s_o   (clk_s),
    .dat_s_o   (dat_s),
    .fall_o    (fall)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ack_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      par_q     <= par_d;
      ack_q     <= ack_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ack_ok_q  <= ack_ok_d;
    end
  end

  // Next state; the watchdog counter restarts on every device clock fall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_d     = par_q;
    ack_d     = ack_q;
    fin_ok_c  = 1'b0;
    fin_err_c = 1'b0;

    watched_c = (state_q == REQ) || (state_q == BITS) ||
                (state_q == ACK) || (state_q == WAIT_IDLE);
    timeout_c = watched_c && !fall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    if (watched_c) begin
      cnt_d = fall ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (cmd_valid && ready_q) begin
          data_d  = cmd_data;
          par_d   = odd_parity(cmd_data);
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQ: begin
        if (fall) begin
          bit_cnt_d = '0;
          state_d   = BITS;
        end
      end
      BITS: begin
        if (fall) begin
          if (bit_cnt_q == LAST_BIT_IDX) begin
            ack_d   = ~dat_s;
            state_d = ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ACK: state_d = WAIT_IDLE;
      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          fin_ok_c  = ack_q;
          fin_err_c = ~ack_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_c) begin
      state_d   = IDLE;
      cnt_d     = '0;
      fin_ok_c  = 1'b0;
      fin_err_c = 1'b1;
    end
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    clk_oe_d  = 1'b0;
    dat_oe_d  = 1'b0;
    cur_bit_c = (bit_cnt_d == PAR_BIT_IDX) ? par_d : data_d[bit_cnt_d[2:0]];

    unique case (state_d)
      INHIBIT: begin
        clk_oe_d = 1'b1;
        dat_oe_d = (cnt_d == CNT_W'(INHIBIT_CYCLES - 1));
      end
      REQ:     dat_oe_d = 1'b1;
      BITS:    dat_oe_d = (bit_cnt_d <= PAR_BIT_IDX) ? ~cur_bit_c : 1'b0;
      default: dat_oe_d = 1'b0;
    endcase

    busy_d   = (state_d != IDLE);
    ready_d  = ~busy_d;
    done_d   = fin_ok_c;
    error_d  = fin_err_c;
    ack_ok_d = (fin_ok_c || fin_err_c) ? fin_ok_c : ack_ok_q;
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign ack_ok     = ack_ok_q;

endmodule
